// File: rtl/tx_buffer_control_pkg.sv
// Shared definitions for the transmit buffer controller: FSM state encoding,
// frame size default and field widths.
package tx_buffer_control_pkg;

  localparam int NBYTES_DEFAULT = 10000 / 8;
  localparam int BYTE_W         = 8;
  localparam int COUNT_W        = 11;
  localparam int TIMER_MIN_W    = 8;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    WAIT_SPACE = 3'd1,
    REQ        = 3'd2,
    ACK        = 3'd3,
    DRAIN      = 3'd4
  } state_t;

  // Watchdog width: wide enough for the timeout value, never below 8 bits.
  function automatic int timer_width(input int timeout);
    return ($clog2(timeout + 1) > TIMER_MIN_W) ? $clog2(timeout + 1) : TIMER_MIN_W;
  endfunction

endpackage

// File: rtl/tx_buffer_control_fifo.sv
// Synchronous byte FIFO with extra-bit wrap pointers; the head is read
// straight from storage, so a pushed byte shows one cycle after its push edge.
module byte_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk_1200,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_1200 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: pointer reset alone discards the contents.
  always_ff @(posedge clk_1200) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/tx_buffer_control.sv
// Transmit buffer controller: pulls one frame byte-by-byte over the rfd/dav/ack
// handshake into an output FIFO, guarded by a sticky handshake watchdog.
module tx_buffer_control
  import tx_buffer_control_pkg::*;
#(
  parameter int NBYTES     = NBYTES_DEFAULT,
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 255
) (
  input  logic               clk_1200,
  input  logic               reset_n,
  input  logic               tx_full,
  input  logic               tx_empty,
  input  logic [BYTE_W-1:0]  datain,
  input  logic               dav_tx,
  output logic               rfd_tx,
  output logic               ack_tx,
  output logic [BYTE_W-1:0]  byte_out,
  output logic               byte_valid,
  input  logic               byte_ready,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic [COUNT_W-1:0] byte_count
);

  localparam int TW = timer_width(TIMEOUT);

  state_t             state;
  state_t             state_next;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      timer_next;
  logic [COUNT_W-1:0] byte_count_next;
  logic               err_next;
  logic               timer_run;
  logic               fifo_push;
  logic               fifo_full;
  logic               fifo_empty;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk_1200 (clk_1200),
    .reset_n  (reset_n),
    .push     (fifo_push),
    .din      (datain),
    .pop      (byte_valid && byte_ready),
    .dout     (byte_out),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign byte_valid = !fifo_empty;

  always_ff @(posedge clk_1200 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      timer       <= '0;
      byte_count  <= '0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      byte_count  <= byte_count_next;
      err_timeout <= err_next;
    end
  end

  always_comb begin
    state_next      = state;
    byte_count_next = byte_count;
    err_next        = err_timeout;
    fifo_push       = 1'b0;
    rfd_tx          = 1'b0;
    ack_tx          = 1'b0;
    done            = 1'b0;
    busy            = (state != IDLE);
    timer_run       = (state == REQ) || (state == ACK) || (state == DRAIN);

    case (state)
      IDLE: begin
        if (tx_full && !err_timeout) begin
          byte_count_next = '0;
          state_next      = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (!fifo_full) state_next = REQ;
      end
      REQ: begin
        rfd_tx = 1'b1;
        if (dav_tx) begin
          fifo_push  = 1'b1;
          state_next = ACK;
        end
      end
      ACK: begin
        ack_tx = 1'b1;
        if (!dav_tx) begin
          byte_count_next = byte_count + 1'b1;
          state_next = (byte_count_next == COUNT_W'(NBYTES)) ? DRAIN : WAIT_SPACE;
        end
      end
      DRAIN: begin
        if (fifo_empty && tx_empty) begin
          done       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // A handshake that has not progressed within the budget aborts the frame.
    if (timer_run && (state_next == state) && (timer == TW'(TIMEOUT - 1))) begin
      err_next   = 1'b1;
      state_next = IDLE;
    end

    timer_next = (!timer_run || (state_next != state)) ? '0 : timer + 1'b1;
  end

endmodule

// File: tb/tb_tx_buffer_control.sv
// Directed-sequence bench with randomized data and byte_ready, checked against
// a queue-based model of the transmit buffer and the output byte stream.
module tb_tx_buffer_control;
  import tx_buffer_control_pkg::*;

  localparam int NBYTES     = 1250;
  localparam int FIFO_DEPTH = 8;
  localparam int TIMEOUT    = 255;

  logic        clk_1200;
  logic        reset_n;
  logic        tx_full;
  logic        tx_empty;
  logic [7:0]  datain;
  logic        dav_tx;
  logic        rfd_tx;
  logic        ack_tx;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        busy;
  logic        done;
  logic        err_timeout;
  logic [10:0] byte_count;

  tx_buffer_control #(
    .NBYTES     (NBYTES),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk_1200    (clk_1200),
    .reset_n     (reset_n),
    .tx_full     (tx_full),
    .tx_empty    (tx_empty),
    .datain      (datain),
    .dav_tx      (dav_tx),
    .rfd_tx      (rfd_tx),
    .ack_tx      (ack_tx),
    .byte_out    (byte_out),
    .byte_valid  (byte_valid),
    .byte_ready  (byte_ready),
    .busy        (busy),
    .done        (done),
    .err_timeout (err_timeout),
    .byte_count  (byte_count)
  );

  initial clk_1200 = 1'b0;
  always #5 clk_1200 = ~clk_1200;

  int         errors     = 0;
  int         checks     = 0;
  logic [7:0] sent_q[$];
  int         remaining  = 0;
  int         acc_cnt    = 0;
  int         rx_cnt     = 0;
  int         done_cnt   = 0;
  int         rfd_cycles = 0;
  int         ready_mode = 0;
  bit         stall      = 1'b0;
  bit         seq_data   = 1'b0;
  logic [7:0] seq_val    = 8'h00;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One cycle: sample after the falling edge, play the buffer side of the
  // handshake, choose byte_ready, and score any byte popped at the next edge.
  task automatic apply_stimulus();
    bit capture_now = 1'b0;
    @(negedge clk_1200);
    #1;
    if (dav_tx && ack_tx) begin
      sent_q.push_back(datain);
      acc_cnt++;
      remaining--;
      dav_tx = 1'b0;
    end else if (!dav_tx && rfd_tx && remaining > 0 && !stall) begin
      datain      = seq_data ? seq_val : 8'($urandom);
      seq_val     = seq_val + 8'd1;
      dav_tx      = 1'b1;
      capture_now = 1'b1;
    end
    tx_empty = (remaining == 0);
    case (ready_mode)
      0:       byte_ready = 1'b0;
      1:       byte_ready = 1'b1;
      2:       byte_ready = 1'($urandom_range(0, 1));
      default: byte_ready = capture_now || (sent_q.size() == FIFO_DEPTH);
    endcase
    check_output("rfd_ack_exclusive", 32'(rfd_tx && ack_tx), 32'd0);
    check_output("byte_valid_occupancy", 32'(byte_valid), 32'(sent_q.size() != 0));
    if (byte_valid && byte_ready && sent_q.size() > 0) begin
      check_output("byte_out_order", 32'(byte_out), 32'(sent_q.pop_front()));
      rx_cnt++;
    end
    if (done) done_cnt++;
    if (rfd_tx) rfd_cycles++;
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    #1;
    check_output("rst_rfd_tx", 32'(rfd_tx), 32'd0);
    check_output("rst_ack_tx", 32'(ack_tx), 32'd0);
    check_output("rst_byte_valid", 32'(byte_valid), 32'd0);
    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_done", 32'(done), 32'd0);
    check_output("rst_err_timeout", 32'(err_timeout), 32'd0);
    check_output("rst_byte_count", 32'(byte_count), 32'd0);
    sent_q.delete();
    remaining  = 0;
    dav_tx     = 1'b0;
    tx_full    = 1'b0;
    ready_mode = 0;
    repeat (2) apply_stimulus();
    reset_n = 1'b1;
    apply_stimulus();
    check_output("rel_rfd_tx", 32'(rfd_tx), 32'd0);
    check_output("rel_ack_tx", 32'(ack_tx), 32'd0);
    check_output("rel_busy", 32'(busy), 32'd0);
  endtask

  task automatic start_frame(input bit seq);
    acc_cnt    = 0;
    rx_cnt     = 0;
    done_cnt   = 0;
    rfd_cycles = 0;
    seq_data   = seq;
    seq_val    = 8'h00;
    remaining  = NBYTES;
    tx_full    = 1'b1;
    apply_stimulus();
    tx_full = 1'b0;
    check_output("start_count_clear", 32'(byte_count), 32'd0);
    check_output("start_busy", 32'(busy), 32'd1);
  endtask

  task automatic wait_accepted(input int target, input int budget);
    int n = 0;
    while (acc_cnt < target && n < budget) begin
      apply_stimulus();
      n++;
    end
  endtask

  task automatic finish_frame(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      apply_stimulus();
      n++;
    end
    repeat (5) apply_stimulus();
    check_output("done_single_pulse", 32'(done_cnt), 32'd1);
    check_output("final_byte_count", 32'(byte_count), 32'(NBYTES));
    check_output("bytes_accepted", 32'(acc_cnt), 32'(NBYTES));
    check_output("bytes_delivered", 32'(rx_cnt), 32'(NBYTES));
    check_output("idle_after_done", 32'(busy), 32'd0);
  endtask

  initial begin
    bit busy_seen;
    int n;
    reset_n    = 1'b1;
    tx_full    = 1'b0;
    tx_empty   = 1'b0;
    datain     = 8'h00;
    dav_tx     = 1'b0;
    byte_ready = 1'b0;
    #2;
    reset_dut();

    $display("[TB] full frame, byte_ready held high");
    ready_mode = 1;
    start_frame(1'b0);
    finish_frame(12000);

    $display("[TB] backpressure then random byte_ready");
    ready_mode = 0;
    start_frame(1'b0);
    repeat (60) apply_stimulus();
    check_output("bp_handshakes", 32'(acc_cnt), 32'(FIFO_DEPTH));
    check_output("bp_rfd_low", 32'(rfd_tx), 32'd0);
    check_output("bp_busy", 32'(busy), 32'd1);
    ready_mode = 2;
    finish_frame(12000);

    $display("[TB] simultaneous push/pop, sequential data");
    ready_mode = 0;
    start_frame(1'b1);
    wait_accepted(1, 50);
    ready_mode = 3;
    wait_accepted(41, 400);
    check_output("occ1_accepted", 32'(acc_cnt), 32'd41);
    check_output("occ1_valid", 32'(byte_valid), 32'd1);
    ready_mode = 0;
    repeat (40) apply_stimulus();
    check_output("fill_to_depth", 32'(acc_cnt), 32'(41 + FIFO_DEPTH - 1));
    check_output("full_rfd_low", 32'(rfd_tx), 32'd0);
    ready_mode = 3;
    wait_accepted(41 + FIFO_DEPTH - 1 + 40, 600);
    check_output("near_full_accepted", 32'(acc_cnt), 32'(81 + FIFO_DEPTH - 1));
    check_output("near_full_valid", 32'(byte_valid), 32'd1);
    ready_mode = 1;
    finish_frame(12000);

    $display("[TB] reset after 100 bytes, then a fresh frame");
    ready_mode = 2;
    start_frame(1'b0);
    wait_accepted(100, 2000);
    check_output("mid_frame_accepted", 32'(acc_cnt), 32'd100);
    reset_dut();
    ready_mode = 1;
    start_frame(1'b0);
    finish_frame(12000);

    $display("[TB] stalled buffer, watchdog");
    stall      = 1'b1;
    ready_mode = 1;
    start_frame(1'b0);
    n = 0;
    while (!err_timeout && n < 4 * TIMEOUT) begin
      apply_stimulus();
      n++;
    end
    check_output("stall_err_timeout", 32'(err_timeout), 32'd1);
    check_output("stall_rfd_cycles", 32'(rfd_cycles), 32'(TIMEOUT));
    check_output("stall_rfd_low", 32'(rfd_tx), 32'd0);
    check_output("stall_idle", 32'(busy), 32'd0);
    tx_full = 1'b1;
    apply_stimulus();
    tx_full   = 1'b0;
    busy_seen = busy || rfd_tx;
    repeat (10) begin
      apply_stimulus();
      if (busy || rfd_tx) busy_seen = 1'b1;
    end
    check_output("err_ignores_tx_full", 32'(busy_seen), 32'd0);
    check_output("err_sticky", 32'(err_timeout), 32'd1);
    stall = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tx_buffer_control.md
TX_BUFFER_CONTROL -- requirements
Module: tx_buffer_control

Interface
REQ-001 Parameter NBYTES, default 1250, number of bytes per 10K-bit transmit frame.
REQ-002 Parameter FIFO_DEPTH, default 8, power of two, output byte FIFO depth.
REQ-003 Parameter TIMEOUT, default 255, max cycles waiting on any buffer handshake edge.
REQ-004 Ports SHALL be:
- clk_1200 in 1: 1200 Hz clock; sole clock, all logic on posedge.
- reset_n in 1: asynchronous, active-low reset.
- tx_full in 1: transmit buffer holds a full frame.
- tx_empty in 1: transmit buffer drained.
- datain in 8: byte from transmit buffer.
- dav_tx in 1: transmit buffer data available.
- rfd_tx out 1: ready for data.
- ack_tx out 1: byte accepted.
- byte_out out 8: FIFO head byte.
- byte_valid out 1: byte_out valid.
- byte_ready in 1: downstream accepts byte_out.
- busy out 1: frame in progress.
- done out 1: one-cycle frame-complete pulse.
- err_timeout out 1: sticky handshake timeout.
- byte_count out 11: bytes accepted in current frame.

Function
REQ-005 FSM states SHALL be IDLE, WAIT_SPACE, REQ, ACK, DRAIN.
REQ-006 IDLE: outputs low except FIFO outputs; on tx_full=1 clear byte_count, go WAIT_SPACE.
REQ-007 WAIT_SPACE: when FIFO not full go REQ; otherwise hold (backpressure), timeout counter not running.
REQ-008 REQ: rfd_tx=1; on dav_tx=1 capture datain into FIFO, rfd_tx=0, ack_tx=1 next cycle, go ACK.
REQ-009 ACK: hold ack_tx=1 until dav_tx=0, then ack_tx=0, byte_count+1; if byte_count reaches NBYTES go DRAIN else WAIT_SPACE.
REQ-010 DRAIN: when FIFO empty and tx_empty=1, pulse done for exactly one cycle, go IDLE.
REQ-011 rfd_tx and ack_tx SHALL never be high in the same cycle.
REQ-012 Timeout counter (8 bits min) SHALL run only in REQ, ACK, DRAIN; clears on each state change; at TIMEOUT set err_timeout, drop rfd_tx/ack_tx, go IDLE.
REQ-013 err_timeout SHALL stay set until reset; tx_full while err_timeout=1 SHALL be ignored.
REQ-014 busy SHALL be 1 in every state except IDLE.
REQ-015 FIFO push only at REQ capture; pop when byte_valid and byte_ready; simultaneous push/pop SHALL keep occupancy unchanged.
REQ-016 Captured byte SHALL appear on byte_out no earlier than one cycle after capture edge; order preserved.
REQ-017 Push when full SHALL be impossible (REQ-007 guard); pop when empty SHALL be ignored.
REQ-018 FIFO pointers SHALL wrap modulo FIFO_DEPTH with an extra bit for full/empty discrimination.
REQ-019 tx_full asserted outside IDLE SHALL be ignored; tx_empty outside DRAIN SHALL be ignored.
REQ-020 byte_count SHALL hold its final value after done until the next frame starts.

Reset
REQ-021 reset_n=0 SHALL immediately force IDLE, FIFO empty, byte_count=0, rfd_tx, ack_tx, byte_valid, busy, done, err_timeout=0.
REQ-022 Reset mid-frame SHALL discard FIFO contents and partial count; no handshake output glitches high on release.

Structure
REQ-023 Shared package SHALL hold state encoding constants and NBYTES default (10000/8).
REQ-024 FIFO SHALL be one sub-module, byte_fifo, parameterised by depth and width.

Verification
REQ-025 Full frame, byte_ready=1: model buffer sends 1250 bytes, tx_empty after last -> 1250 bytes out in order, done one pulse, byte_count=1250.
REQ-026 Backpressure: byte_ready=0 -> exactly 8 handshakes then rfd_tx stays 0; byte_ready=1 -> transfer resumes, no loss.
REQ-027 Stall: dav_tx never rises after rfd_tx -> err_timeout=1 after 255 cycles, rfd_tx=0, IDLE, next tx_full ignored.
REQ-028 Reset mid-frame after 100 bytes -> all outputs 0, byte_valid=0; new frame completes with 1250 bytes.
REQ-029 Pop/push same cycle at occupancy 1 and at FIFO_DEPTH -> occupancy constant, data 0x00..0xFF sequence intact.
